forwarding_ctrl: RTL and testbench
==================================

# forwarding_ctrl

Hazard and forwarding controller for the 5-stage integer pipeline: produces the 2-bit select codes consumed by the EX-stage operand forwarding multiplexers and the load-use stall request consumed by the PC / IF-ID hold logic. It keeps its own shadow copy of register identifiers and control bits through ID/EX, EX/MEM and MEM/WB, so the datapath pipeline registers need not export them. A saturating counter of stall cycles is provided for fault-tracking and debug.

## Interface
- COUNT_W, 16, width of stall-cycle counter
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  asynchronous, active-low reset
- id_valid_i  in  1  ID stage holds a real instruction
- id_rs1_i  in  5  ID source register 1
- id_rs2_i  in  5  ID source register 2
- id_rd_i  in  5  ID destination register
- id_reg_write_i  in  1  ID instruction writes rd
- id_mem_read_i  in  1  ID instruction is a load
- flush_i  in  1  squash ID instruction (taken branch/jump)
- forward_a_o  out  2  select for EX operand A
- forward_b_o  out  2  select for EX operand B
- stall_o  out  1  load-use stall request (hold PC and IF/ID)
- stall_count_o  out  COUNT_W  saturating count of cycles with stall_o=1

## Operation
- Select encoding (must match the forwarding mux): 2'b00 no forward (register-file data), 2'b10 EX/MEM result, 2'b01 MEM/WB result; 2'b11 never driven.
- Shadow stages: EX holds {v, rs1, rs2, rd, rw, mr}; MEM holds {v, rd, rw, mr}; WB holds {v, rd, rw}.
- Each cycle: WB<-MEM, MEM<-EX unconditionally; EX<-ID fields with v=id_valid_i, unless bubble.
- Bubble (EX.v<=0, other EX fields don't-care) when stall_o=1 or flush_i=1.
- Forward for operand X (rs = EX.rs1 or EX.rs2), only when EX.v=1 and rs!=0:
  - 2'b10 if MEM.v & MEM.rw & !MEM.mr & MEM.rd==rs;
  - else 2'b01 if WB.v & WB.rw & WB.rd==rs;
  - else 2'b00. EX/MEM has priority over MEM/WB.
- Load-use: stall_o=1 when id_valid_i & EX.v & EX.mr & EX.rd!=0 & (EX.rd==id_rs1_i | EX.rd==id_rs2_i) & !flush_i.
- Rs2 compared regardless of format; spurious stalls on non-rs2 instructions are accepted.
- Register-file write-then-read in the same cycle (WB vs ID) is the register file's responsibility, not this block's.
- stall_count_o increments by 1 on every clock with stall_o=1; holds at all-ones (no wrap).

## Timing
- Reset (rst_i=0, asynchronous): all v bits 0, all other shadow fields 0, stall_count_o=0; therefore forward_a_o=forward_b_o=2'b00, stall_o=0 immediately and while reset held.
- forward_*_o, stall_o: combinational from shadow state and ID inputs, valid same cycle, no added latency.
- Load-use costs exactly one stall cycle: next cycle the load is in MEM, EX holds the bubble, stall_o falls; following cycle the consumer is in EX with the load in WB -> select 2'b01.
- Simultaneous stall condition and flush_i: flush wins; stall_o=0, bubble inserted, counter unchanged.
- Reset released mid-program: pipeline treated as empty; no forwarding until real instructions reach MEM/WB.

## Structure
- Shared package/header fwd_pkg: FWD_NONE=2'b00, FWD_MEM_WB=2'b01, FWD_EX_MEM=2'b10, REG_ZERO=5'd0, REG_ADDR_W=5; the forwarding mux and this block both use it.
- One sub-module fwd_select (combinational, rs + MEM/WB shadow fields -> 2-bit select), instantiated twice for operands A and B. Shadow registers, stall logic and counter stay in the top.

## Test plan
- Reset: hold rst_i=0, drive random ID inputs -> forward_*=00, stall_o=0, stall_count_o=0 throughout.
- add x5 then sub x6,x5,x5 back-to-back -> with sub in EX, forward_a_o=forward_b_o=2'b10; no stall.
- add x5; nop; or x7,x5,x1 -> with or in EX, forward_a_o=2'b01, forward_b_o=2'b00; add x5 twice back-to-back then use x5 -> 2'b10 (priority).
- lw x8 then add x9,x8,x2 -> stall_o=1 for exactly one cycle, stall_count_o 0->1, then forward_a_o=2'b01; same with rd=x0 -> no stall, selects 00.
- lw x8 followed by dependent add with flush_i=1 in the same cycle -> stall_o=0, counter unchanged, EX bubble (selects 00 next cycle).
- Force 2^COUNT_W+3 stall cycles -> stall_count_o saturates at all-ones; assert rst_i low mid-stall -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/fwd_pkg.sv
// Shared definitions for the EX-stage operand forwarding path: select codes,
// register-address width and the shadow pipeline record layouts.
package fwd_pkg;

  localparam int REG_ADDR_W = 5;

  localparam logic [1:0] FWD_NONE   = 2'b00;
  localparam logic [1:0] FWD_MEM_WB = 2'b01;
  localparam logic [1:0] FWD_EX_MEM = 2'b10;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

  typedef struct packed {
    logic      v;
    reg_addr_t rs1;
    reg_addr_t rs2;
    reg_addr_t rd;
    logic      rw;
    logic      mr;
  } ex_shadow_t;

  typedef struct packed {
    logic      v;
    reg_addr_t rd;
    logic      rw;
    logic      mr;
  } mem_shadow_t;

  typedef struct packed {
    logic      v;
    reg_addr_t rd;
    logic      rw;
  } wb_shadow_t;

  // x0 is hardwired, so a destination of x0 never produces a value to bypass.
  function automatic logic rd_hit(input reg_addr_t rd, input reg_addr_t rs);
    return (rd != REG_ZERO) && (rd == rs);
  endfunction

endpackage

// File: rtl/fwd_select.sv
// Forwarding select for one EX operand: picks EX/MEM over MEM/WB results,
// falling back to register-file data.
module fwd_select
  import fwd_pkg::*;
(
  input  logic      en_i,
  input  reg_addr_t rs_i,
  input  logic      mem_v_i,
  input  logic      mem_rw_i,
  input  logic      mem_mr_i,
  input  reg_addr_t mem_rd_i,
  input  logic      wb_v_i,
  input  logic      wb_rw_i,
  input  reg_addr_t wb_rd_i,
  output logic [1:0] sel_o
);

  logic mem_hit_s;
  logic wb_hit_s;

  // A load still in MEM has no data yet; the stall logic keeps it out of this path.
  always_comb begin
    mem_hit_s = mem_v_i && mem_rw_i && !mem_mr_i && rd_hit(mem_rd_i, rs_i);
    wb_hit_s  = wb_v_i && wb_rw_i && rd_hit(wb_rd_i, rs_i);
    if (!en_i) begin
      sel_o = FWD_NONE;
    end else if (mem_hit_s) begin
      sel_o = FWD_EX_MEM;
    end else if (wb_hit_s) begin
      sel_o = FWD_MEM_WB;
    end else begin
      sel_o = FWD_NONE;
    end
  end

endmodule

// File: rtl/forwarding_ctrl.sv
// Hazard/forwarding controller: shadows register ids through EX/MEM/WB,
// drives operand forwarding selects, load-use stall and a saturating stall counter.
module forwarding_ctrl
  import fwd_pkg::*;
#(
  parameter int COUNT_W = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               id_valid_i,
  input  logic [4:0]         id_rs1_i,
  input  logic [4:0]         id_rs2_i,
  input  logic [4:0]         id_rd_i,
  input  logic               id_reg_write_i,
  input  logic               id_mem_read_i,
  input  logic               flush_i,
  output logic [1:0]         forward_a_o,
  output logic [1:0]         forward_b_o,
  output logic               stall_o,
  output logic [COUNT_W-1:0] stall_count_o
);

  ex_shadow_t         ex_q,  ex_d;
  mem_shadow_t        mem_q, mem_d;
  wb_shadow_t         wb_q,  wb_d;
  logic [COUNT_W-1:0] stall_count_q, stall_count_d;
  logic               stall_s;
  logic               bubble_s;

  // Flush squashes the consumer, so a pending load-use stall is moot.
  always_comb begin
    stall_s  = id_valid_i && ex_q.v && ex_q.mr && !flush_i &&
               (rd_hit(ex_q.rd, id_rs1_i) || rd_hit(ex_q.rd, id_rs2_i));
    bubble_s = stall_s || flush_i;
  end

  always_comb begin
    if (bubble_s) begin
      ex_d = '0;
    end else begin
      ex_d.v   = id_valid_i;
      ex_d.rs1 = id_rs1_i;
      ex_d.rs2 = id_rs2_i;
      ex_d.rd  = id_rd_i;
      ex_d.rw  = id_reg_write_i;
      ex_d.mr  = id_mem_read_i;
    end
    mem_d.v  = ex_q.v;
    mem_d.rd = ex_q.rd;
    mem_d.rw = ex_q.rw;
    mem_d.mr = ex_q.mr;
    wb_d.v   = mem_q.v;
    wb_d.rd  = mem_q.rd;
    wb_d.rw  = mem_q.rw;
    if (stall_s && !(&stall_count_q)) begin
      stall_count_d = stall_count_q + {{(COUNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_count_d = stall_count_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ex_q          <= '0;
      mem_q         <= '0;
      wb_q          <= '0;
      stall_count_q <= '0;
    end else begin
      ex_q          <= ex_d;
      mem_q         <= mem_d;
      wb_q          <= wb_d;
      stall_count_q <= stall_count_d;
    end
  end

  fwd_select u_sel_a (
    .en_i     (ex_q.v),
    .rs_i     (ex_q.rs1),
    .mem_v_i  (mem_q.v),
    .mem_rw_i (mem_q.rw),
    .mem_mr_i (mem_q.mr),
    .mem_rd_i (mem_q.rd),
    .wb_v_i   (wb_q.v),
    .wb_rw_i  (wb_q.rw),
    .wb_rd_i  (wb_q.rd),
    .sel_o    (forward_a_o)
  );

  fwd_select u_sel_b (
    .en_i     (ex_q.v),
    .rs_i     (ex_q.rs2),
    .mem_v_i  (mem_q.v),
    .mem_rw_i (mem_q.rw),
    .mem_mr_i (mem_q.mr),
    .mem_rd_i (mem_q.rd),
    .wb_v_i   (wb_q.v),
    .wb_rw_i  (wb_q.rw),
    .wb_rd_i  (wb_q.rd),
    .sel_o    (forward_b_o)
  );

  assign stall_o       = stall_s;
  assign stall_count_o = stall_count_q;

endmodule

// File: tb/tb_forwarding_ctrl.sv
// Directed bench for forwarding_ctrl: a per-cycle vector table for the
// forwarding/stall scenarios plus hand sequences for reset and saturation.
module tb_forwarding_ctrl;

  localparam int CW      = 6;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          id_valid;
  logic [4:0]    id_rs1, id_rs2, id_rd;
  logic          id_rw, id_mr, flush;
  logic [1:0]    fwd_a, fwd_b;
  logic          stall;
  logic [CW-1:0] stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  forwarding_ctrl #(.COUNT_W(CW)) dut (
    .clk_i          (clk),
    .rst_i          (rst_n),
    .id_valid_i     (id_valid),
    .id_rs1_i       (id_rs1),
    .id_rs2_i       (id_rs2),
    .id_rd_i        (id_rd),
    .id_reg_write_i (id_rw),
    .id_mem_read_i  (id_mr),
    .flush_i        (flush),
    .forward_a_o    (fwd_a),
    .forward_b_o    (fwd_b),
    .stall_o        (stall),
    .stall_count_o  (stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [4:0] rs1, rs2, rd;
    logic       rw, mr, fl;
    logic [1:0] ea, eb;
    logic       es;
    int         ec;
  } vec_t;

  vec_t vecs[33];

  function automatic vec_t mk(input logic v, input int rs1, input int rs2, input int rd,
                              input logic rw, input logic mr, input logic fl,
                              input logic [1:0] ea, input logic [1:0] eb,
                              input logic es, input int ec);
    vec_t r;
    r.v = v; r.rs1 = 5'(rs1); r.rs2 = 5'(rs2); r.rd = 5'(rd);
    r.rw = rw; r.mr = mr; r.fl = fl;
    r.ea = ea; r.eb = eb; r.es = es; r.ec = ec;
    return r;
  endfunction

  function automatic vec_t nop(input logic [1:0] ea, input logic [1:0] eb, input int ec);
    return mk(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, ea, eb, 1'b0, ec);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input int rs1, input int rs2, input int rd,
                       input logic rw, input logic mr, input logic fl);
    id_valid = v; id_rs1 = 5'(rs1); id_rs2 = 5'(rs2); id_rd = 5'(rd);
    id_rw = rw; id_mr = mr; flush = fl;
  endtask

  task automatic check_all(input string tag, input logic [1:0] ea, input logic [1:0] eb,
                           input logic es, input int ec);
    check({tag, ".fwd_a"}, 32'(fwd_a), 32'(ea));
    check({tag, ".fwd_b"}, 32'(fwd_b), 32'(eb));
    check({tag, ".stall"}, 32'(stall), 32'(es));
    check({tag, ".count"}, 32'(stall_cnt), 32'(ec));
  endtask

  int exp_cnt;

  initial begin
    // Columns: v rs1 rs2 rd rw mr flush | fwd_a fwd_b stall count(before edge)
    vecs[0]  = mk(1, 1, 2, 5, 1, 0, 0, 2'b00, 2'b00, 0, 0);   // add x5,x1,x2
    vecs[1]  = mk(1, 5, 5, 6, 1, 0, 0, 2'b00, 2'b00, 0, 0);   // sub x6,x5,x5
    vecs[2]  = nop(2'b10, 2'b10, 0);
    vecs[3]  = nop(2'b00, 2'b00, 0);
    vecs[4]  = mk(1, 1, 2, 5, 1, 0, 0, 2'b00, 2'b00, 0, 0);   // add x5
    vecs[5]  = nop(2'b00, 2'b00, 0);
    vecs[6]  = mk(1, 5, 1, 7, 1, 0, 0, 2'b00, 2'b00, 0, 0);   // or x7,x5,x1
    vecs[7]  = nop(2'b01, 2'b00, 0);
    vecs[8]  = mk(1, 1, 2, 5, 1, 0, 0, 2'b00, 2'b00, 0, 0);   // add x5
    vecs[9]  = mk(1, 1, 3, 5, 1, 0, 0, 2'b00, 2'b00, 0, 0);   // add x5 again
    vecs[10] = mk(1, 5, 0, 10, 1, 0, 0, 2'b00, 2'b00, 0, 0);  // use x5, rs2=x0
    vecs[11] = nop(2'b10, 2'b00, 0);
    vecs[12] = nop(2'b00, 2'b00, 0);
    vecs[13] = nop(2'b00, 2'b00, 0);
    vecs[14] = mk(1, 1, 0, 8, 1, 1, 0, 2'b00, 2'b00, 0, 0);   // lw x8
    vecs[15] = mk(1, 8, 2, 9, 1, 0, 0, 2'b00, 2'b00, 1, 0);   // add x9,x8,x2 stalls
    vecs[16] = mk(1, 8, 2, 9, 1, 0, 0, 2'b00, 2'b00, 0, 1);   // held, issues
    vecs[17] = nop(2'b01, 2'b00, 1);
    vecs[18] = nop(2'b00, 2'b00, 1);
    vecs[19] = mk(1, 1, 0, 0, 1, 1, 0, 2'b00, 2'b00, 0, 1);   // lw x0
    vecs[20] = mk(1, 0, 2, 9, 1, 0, 0, 2'b00, 2'b00, 0, 1);   // add x9,x0,x2
    vecs[21] = nop(2'b00, 2'b00, 1);
    vecs[22] = nop(2'b00, 2'b00, 1);
    vecs[23] = mk(1, 1, 0, 8, 1, 1, 0, 2'b00, 2'b00, 0, 1);   // lw x8
    vecs[24] = mk(1, 8, 2, 9, 1, 0, 1, 2'b00, 2'b00, 0, 1);   // dependent, flushed
    vecs[25] = nop(2'b00, 2'b00, 1);
    vecs[26] = mk(1, 3, 0, 12, 1, 1, 0, 2'b00, 2'b00, 0, 1);  // lw x12
    vecs[27] = mk(1, 4, 12, 0, 0, 0, 0, 2'b00, 2'b00, 1, 1);  // store using x12 as rs2
    vecs[28] = mk(1, 4, 12, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2);
    vecs[29] = nop(2'b00, 2'b01, 2);
    vecs[30] = mk(1, 1, 0, 8, 1, 1, 0, 2'b00, 2'b00, 0, 2);   // lw x8
    vecs[31] = mk(0, 8, 8, 8, 1, 1, 0, 2'b00, 2'b00, 0, 2);   // invalid ID never stalls
    vecs[32] = nop(2'b00, 2'b00, 2);

    // Reset held with random ID traffic.
    rst_n = 1'b0;
    drive(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive(1'b1, int'($urandom_range(31)), int'($urandom_range(31)),
            int'($urandom_range(31)), 1'b1, 1'b1, 1'b0);
      #1;
      check_all($sformatf("reset%0d", i), 2'b00, 2'b00, 1'b0, 0);
    end
    @(negedge clk);
    drive(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < 33; i++) begin
      @(negedge clk);
      drive(vecs[i].v, int'(vecs[i].rs1), int'(vecs[i].rs2), int'(vecs[i].rd),
            vecs[i].rw, vecs[i].mr, vecs[i].fl);
      #1;
      check_all($sformatf("vec%0d", i), vecs[i].ea, vecs[i].eb, vecs[i].es, vecs[i].ec);
    end

    // Repeated load-use pairs drive the counter into saturation.
    exp_cnt = 2;
    for (int i = 0; i < CNT_MAX + 4; i++) begin
      @(negedge clk);
      drive(1'b1, 1, 0, 8, 1'b1, 1'b1, 1'b0);
      #1;
      check($sformatf("sat%0d.nostall", i), 32'(stall), 32'd0);
      @(negedge clk);
      drive(1'b1, 8, 2, 9, 1'b1, 1'b0, 1'b0);
      #1;
      check($sformatf("sat%0d.stall", i), 32'(stall), 32'd1);
      check($sformatf("sat%0d.count", i), 32'(stall_cnt), 32'(exp_cnt));
      if (exp_cnt < CNT_MAX) exp_cnt++;
    end
    @(negedge clk);
    drive(1'b1, 1, 0, 8, 1'b1, 1'b1, 1'b0);
    #1;
    check("sat.final", 32'(stall_cnt), 32'(CNT_MAX));

    // Asynchronous reset in the middle of a stall.
    @(negedge clk);
    drive(1'b1, 8, 2, 9, 1'b1, 1'b0, 1'b0);
    #1;
    check("midrst.pre_stall", 32'(stall), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check_all("midrst", 2'b00, 2'b00, 1'b0, 0);
    @(negedge clk);
    #1;
    check_all("midrst.held", 2'b00, 2'b00, 1'b0, 0);

    // After release the pipeline is empty: nothing to forward or stall on.
    drive(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    drive(1'b1, 8, 8, 9, 1'b1, 1'b0, 1'b0);
    #1;
    check_all("post_rst.id", 2'b00, 2'b00, 1'b0, 0);
    @(negedge clk);
    drive(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    #1;
    check_all("post_rst.ex", 2'b00, 2'b00, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
